// File: rtl/sym_err_pkg.sv
// Shared types and helpers for the symbol/bit error checker.
// Symbol width, FSM state encoding and a 2-bit population count.
package sym_err_pkg;

  localparam int SYM_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    COUNT = 2'd2
  } state_t;

  function automatic logic [1:0] popcount2(input logic [SYM_W-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/sym_delay_line.sv
// Reference-symbol delay line: shifts on each symbol strobe, tap selects the entry
// `tap` symbols old; tap 0 bypasses straight to the incoming symbol.
module sym_delay_line
  import sym_err_pkg::*;
#(
  parameter int MAX_DELAY = 16,
  parameter int DLY_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [SYM_W-1:0] sym_in,
  input  logic [DLY_W-1:0] tap,
  output logic [SYM_W-1:0] sym_out
);

  // dl_reg[i] holds the symbol i+1 strobes old
  logic [SYM_W-1:0] dl_reg [MAX_DELAY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_DELAY-1; i++) dl_reg[i] <= '0;
    end else if (shift_en) begin
      dl_reg[0] <= sym_in;
      for (int i = 1; i < MAX_DELAY-1; i++) dl_reg[i] <= dl_reg[i-1];
    end
  end

  always_comb begin
    sym_out = sym_in;
    for (int i = 1; i < MAX_DELAY; i++) begin
      if (tap == DLY_W'(i)) sym_out = dl_reg[i-1];
    end
  end

endmodule

// File: rtl/sym_err_counter.sv
// Windowed symbol/bit error counter against a delayed reference stream.
// Define SYM_ERR_BIT_COUNT_EN to build the bit-error accumulator; otherwise bit_err_count is 0.
module sym_err_counter
  import sym_err_pkg::*;
#(
  parameter int WINDOW    = 1024,
  parameter int MAX_DELAY = 16,
  parameter int DLY_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_clk_ena,
  input  logic [SYM_W-1:0] ref_sym,
  input  logic             ref_rollover,
  input  logic [SYM_W-1:0] rx_sym,
  input  logic [DLY_W-1:0] delay,
  output logic [CNT_W-1:0] sym_err_count,
  output logic [CNT_W-1:0] bit_err_count,
  output logic             result_valid,
  output logic             busy
);

  localparam int SC_W = $clog2(WINDOW);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(WINDOW-1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [1:0] inc);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, acc} + {{CNT_W{1'b0}}, inc};
    return (sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  state_t           state_reg, state_next;
  logic [DLY_W-1:0] delay_q_reg, delay_q_next;
  logic [DLY_W-1:0] fill_cnt_reg, fill_cnt_next;
  logic [SC_W-1:0]  sym_cnt_reg, sym_cnt_next;
  logic [CNT_W-1:0] sym_acc_reg, sym_acc_next;
  logic [CNT_W-1:0] sym_out_reg, sym_out_next;
  logic             valid_reg, valid_next;
  logic [DLY_W-1:0] delay_clamped;
  logic [SYM_W-1:0] ref_aligned;
  logic [SYM_W-1:0] xor_sym;
  logic [CNT_W-1:0] sym_acc_upd;
`ifdef SYM_ERR_BIT_COUNT_EN
  logic [CNT_W-1:0] bit_acc_reg, bit_acc_next;
  logic [CNT_W-1:0] bit_out_reg, bit_out_next;
  logic [CNT_W-1:0] bit_acc_upd;
`endif

  // Clamp only exists when the port can express an out-of-range delay
  generate
    if (MAX_DELAY < (1 << DLY_W)) begin : g_clamp
      assign delay_clamped = (delay > DLY_W'(MAX_DELAY-1)) ? DLY_W'(MAX_DELAY-1) : delay;
    end else begin : g_noclamp
      assign delay_clamped = delay;
    end
  endgenerate

  sym_delay_line #(
    .MAX_DELAY(MAX_DELAY),
    .DLY_W    (DLY_W)
  ) u_delay_line (
    .clk     (clk),
    .reset   (reset),
    .shift_en(sym_clk_ena),
    .sym_in  (ref_sym),
    .tap     (delay_q_reg),
    .sym_out (ref_aligned)
  );

  assign xor_sym     = rx_sym ^ ref_aligned;
  assign sym_acc_upd = sat_add(sym_acc_reg, {1'b0, |xor_sym});
`ifdef SYM_ERR_BIT_COUNT_EN
  assign bit_acc_upd = sat_add(bit_acc_reg, popcount2(xor_sym));
`endif

  always_comb begin
    state_next    = state_reg;
    delay_q_next  = delay_q_reg;
    fill_cnt_next = fill_cnt_reg;
    sym_cnt_next  = sym_cnt_reg;
    sym_acc_next  = sym_acc_reg;
    sym_out_next  = sym_out_reg;
    valid_next    = 1'b0;
`ifdef SYM_ERR_BIT_COUNT_EN
    bit_acc_next  = bit_acc_reg;
    bit_out_next  = bit_out_reg;
`endif
    case (state_reg)
      IDLE: begin
        // A strobe coinciding with the rollover only shifts the delay line
        if (ref_rollover) begin
          delay_q_next  = delay_clamped;
          fill_cnt_next = '0;
          sym_cnt_next  = '0;
          sym_acc_next  = '0;
`ifdef SYM_ERR_BIT_COUNT_EN
          bit_acc_next  = '0;
`endif
          state_next    = (delay_clamped == '0) ? COUNT : FILL;
        end
      end
      FILL: begin
        if (sym_clk_ena) begin
          fill_cnt_next = fill_cnt_reg + DLY_W'(1);
          if (fill_cnt_reg == delay_q_reg - DLY_W'(1)) state_next = COUNT;
        end
      end
      COUNT: begin
        if (sym_clk_ena) begin
          if (sym_cnt_reg == SC_LAST) begin
            // Closing symbol is folded into the published totals
            sym_out_next = sym_acc_upd;
            sym_acc_next = '0;
            sym_cnt_next = '0;
            valid_next   = 1'b1;
`ifdef SYM_ERR_BIT_COUNT_EN
            bit_out_next = bit_acc_upd;
            bit_acc_next = '0;
`endif
          end else begin
            sym_acc_next = sym_acc_upd;
            sym_cnt_next = sym_cnt_reg + SC_W'(1);
`ifdef SYM_ERR_BIT_COUNT_EN
            bit_acc_next = bit_acc_upd;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      delay_q_reg  <= '0;
      fill_cnt_reg <= '0;
      sym_cnt_reg  <= '0;
      sym_acc_reg  <= '0;
      sym_out_reg  <= '0;
      valid_reg    <= 1'b0;
`ifdef SYM_ERR_BIT_COUNT_EN
      bit_acc_reg  <= '0;
      bit_out_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      delay_q_reg  <= delay_q_next;
      fill_cnt_reg <= fill_cnt_next;
      sym_cnt_reg  <= sym_cnt_next;
      sym_acc_reg  <= sym_acc_next;
      sym_out_reg  <= sym_out_next;
      valid_reg    <= valid_next;
`ifdef SYM_ERR_BIT_COUNT_EN
      bit_acc_reg  <= bit_acc_next;
      bit_out_reg  <= bit_out_next;
`endif
    end
  end

  assign sym_err_count = sym_out_reg;
`ifdef SYM_ERR_BIT_COUNT_EN
  assign bit_err_count = bit_out_reg;
`else
  assign bit_err_count = '0;
`endif
  assign result_valid  = valid_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_sym_err_counter.sv
// Scoreboard bench for sym_err_counter: directed windows push expected totals,
// monitors pop and compare on every result_valid pulse.
module tb_sym_err_counter;

  localparam int WINDOW    = 1024;
  localparam int MAX_DELAY = 16;
  localparam int DLY_W     = 4;
  localparam int CNT_W     = 16;
  localparam int S_WINDOW  = 16;
  localparam int S_CNT_W   = 4;
`ifdef SYM_ERR_BIT_COUNT_EN
  localparam bit BIT_EN = 1'b1;
`else
  localparam bit BIT_EN = 1'b0;
`endif

  typedef struct {
    int tag;
    int sym_lo;
    int sym_hi;
    int bit_lo;
    int bit_hi;
    int idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic             reset, sym_clk_ena, ref_rollover;
  logic [1:0]       ref_sym, rx_sym;
  logic [DLY_W-1:0] delay;
  logic [CNT_W-1:0] sym_err_count, bit_err_count;
  logic             result_valid, busy;

  // small saturating instance
  logic               s_reset, s_ena, s_roll;
  logic [1:0]         s_ref, s_rx;
  logic [DLY_W-1:0]   s_delay;
  logic [S_CNT_W-1:0] s_sym, s_bit;
  logic               s_valid, s_busy;

  sym_err_counter #(
    .WINDOW(WINDOW), .MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .ref_sym(ref_sym),
    .ref_rollover(ref_rollover), .rx_sym(rx_sym), .delay(delay),
    .sym_err_count(sym_err_count), .bit_err_count(bit_err_count),
    .result_valid(result_valid), .busy(busy)
  );

  sym_err_counter #(
    .WINDOW(S_WINDOW), .MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W), .CNT_W(S_CNT_W)
  ) dut_sat (
    .clk(clk), .reset(s_reset), .sym_clk_ena(s_ena), .ref_sym(s_ref),
    .ref_rollover(s_roll), .rx_sym(s_rx), .delay(s_delay),
    .sym_err_count(s_sym), .bit_err_count(s_bit),
    .result_valid(s_valid), .busy(s_busy)
  );

  exp_t q_main[$];
  exp_t q_small[$];
  exp_t e_main, e_small;
  int   errors = 0;
  int   checks = 0;
  int   strobe_cnt = 0;
  int   s_strobe_cnt = 0;
  int   true_dly = 3;
  bit   chk_busy = 1'b0;
  logic [1:0] hist [16];

  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && result_valid) begin
      if (q_main.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got result_valid=1 (sym=%0d), want 0", sym_err_count);
      end else begin
        e_main = q_main.pop_front();
        $display("t%0d pulse: sym=%0d bit=%0d strobe=%0d", e_main.tag, sym_err_count,
                 bit_err_count, strobe_cnt);
        check($sformatf("t%0d_sym", e_main.tag), int'(sym_err_count), e_main.sym_lo, e_main.sym_hi);
        check($sformatf("t%0d_bit", e_main.tag), int'(bit_err_count), e_main.bit_lo, e_main.bit_hi);
        check($sformatf("t%0d_idx", e_main.tag), strobe_cnt, e_main.idx, e_main.idx);
      end
    end
  end

  always @(negedge clk) begin
    if (!s_reset && s_valid) begin
      if (q_small.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sat_pulse: got result_valid=1 (sym=%0d), want 0", s_sym);
      end else begin
        e_small = q_small.pop_front();
        $display("t%0d pulse: sym=%0d bit=%0d strobe=%0d", e_small.tag, s_sym, s_bit, s_strobe_cnt);
        check("t5_sym", int'(s_sym), e_small.sym_lo, e_small.sym_hi);
        check("t5_bit", int'(s_bit), e_small.bit_lo, e_small.bit_hi);
        check("t5_idx", s_strobe_cnt, e_small.idx, e_small.idx);
      end
    end
  end

  // One symbol strobe every two clocks; rx follows ref by true_dly symbols, xor flip
  task automatic strobe(input logic roll, input logic [1:0] flip);
    logic [1:0] r, aligned;
    @(negedge clk);
    if (chk_busy) check("busy", int'(busy), 1, 1);
    r = 2'($urandom);
    aligned = (true_dly == 0) ? r : hist[true_dly-1];
    ref_sym = r;
    rx_sym = aligned ^ flip;
    ref_rollover = roll;
    sym_clk_ena = 1'b1;
    strobe_cnt++;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = r;
    @(negedge clk);
    sym_clk_ena = 1'b0;
    ref_rollover = 1'b0;
  endtask

  task automatic arm(input int dly, input logic [1:0] flip);
    delay = DLY_W'(dly);
    strobe(1'b1, flip);
    strobe_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sym_clk_ena = 1'b0;
    ref_rollover = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) hist[i] = 2'b00;
    reset = 1'b0;
  endtask

  task automatic run_window(input int tag, input int sym_lo, input int sym_hi,
                            input int bit_lo, input int bit_hi, input int fa, input int fb,
                            input int fc, input int roll_at, input int idx);
    logic [1:0] f;
    exp_t e;
    for (int s = 0; s < WINDOW; s++) begin
      f = (s == fa || s == fb) ? 2'b01 : ((s == fc) ? 2'b11 : 2'b00);
      if (s == WINDOW-1) begin
        e.tag = tag; e.sym_lo = sym_lo; e.sym_hi = sym_hi;
        e.bit_lo = bit_lo; e.bit_hi = bit_hi; e.idx = idx;
        q_main.push_back(e);
      end
      strobe(logic'(s == roll_at), f);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; sym_clk_ena = 1'b0; ref_rollover = 1'b0;
    ref_sym = 2'b00; rx_sym = 2'b00; delay = '0;
    s_reset = 1'b1; s_ena = 1'b0; s_roll = 1'b0; s_ref = 2'b00; s_rx = 2'b00; s_delay = '0;
    for (int i = 0; i < 16; i++) hist[i] = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_sym", int'(sym_err_count), 0, 0);
    check("rst_bit", int'(bit_err_count), 0, 0);
    check("rst_valid", int'(result_valid), 0, 0);
    check("rst_busy", int'(busy), 0, 0);

    // 1: aligned data, three back-to-back windows; stray rollover in window 2
    repeat (5) strobe(1'b0, 2'b00);
    check("idle_busy", int'(busy), 0, 0);
    arm(3, 2'b00);
    chk_busy = 1'b1;
    repeat (3) strobe(1'b0, 2'b11);
    run_window(1, 0, 0, 0, 0, -1, -1, -1, -1, 3 + WINDOW);
    run_window(1, 0, 0, 0, 0, -1, -1, -1, 100, 3 + 2*WINDOW);
    run_window(1, 0, 0, 0, 0, -1, -1, -1, -1, 3 + 3*WINDOW);
    chk_busy = 1'b0;

    // 2: three injected errors, four bits
    do_reset();
    repeat (5) strobe(1'b0, 2'b00);
    arm(3, 2'b00);
    repeat (3) strobe(1'b0, 2'b11);
    run_window(2, 3, 3, BIT_EN ? 4 : 0, BIT_EN ? 4 : 0, 10, 500, 700, -1, 3 + WINDOW);
    run_window(2, 0, 0, 0, 0, -1, -1, -1, -1, 3 + 2*WINDOW);

    // 3: delay mis-set by one symbol against random data
    do_reset();
    repeat (5) strobe(1'b0, 2'b00);
    arm(2, 2'b00);
    repeat (2) strobe(1'b0, 2'b00);
    run_window(3, 708, 828, BIT_EN ? 924 : 0, BIT_EN ? 1124 : 0, -1, -1, -1, -1, 2 + WINDOW);

    // 4: reset 600 symbols into the next window
    repeat (600) strobe(1'b0, 2'b00);
    do_reset();
    check("t4_rst_sym", int'(sym_err_count), 0, 0);
    check("t4_rst_bit", int'(bit_err_count), 0, 0);
    check("t4_rst_busy", int'(busy), 0, 0);
    repeat (20) strobe(1'b0, 2'b00);
    check("t4_idle_busy", int'(busy), 0, 0);
    arm(3, 2'b00);
    repeat (3) strobe(1'b0, 2'b00);
    run_window(4, 0, 0, 0, 0, -1, -1, -1, -1, 3 + WINDOW);

    // 6: delay 0, coincident rollover strobe carries a mismatch that must not count
    do_reset();
    repeat (5) strobe(1'b0, 2'b00);
    true_dly = 0;
    arm(0, 2'b11);
    check("t6_busy", int'(busy), 1, 1);
    run_window(6, 0, 0, 0, 0, -1, -1, -1, -1, WINDOW);
    repeat (4) @(negedge clk);

    // 5: small counters, every symbol wrong in both bits
    s_reset = 1'b0;
    @(negedge clk);
    s_ref = 2'($urandom); s_rx = s_ref; s_roll = 1'b1; s_ena = 1'b1;
    @(negedge clk);
    s_roll = 1'b0; s_ena = 1'b0;
    s_strobe_cnt = 0;
    for (int k = 1; k <= 2*S_WINDOW; k++) begin
      @(negedge clk);
      s_ref = 2'($urandom); s_rx = ~s_ref; s_ena = 1'b1;
      s_strobe_cnt = k;
      if (k % S_WINDOW == 0) begin
        e.tag = 5; e.sym_lo = 15; e.sym_hi = 15;
        e.bit_lo = BIT_EN ? 15 : 0; e.bit_hi = BIT_EN ? 15 : 0; e.idx = k;
        q_small.push_back(e);
      end
      @(negedge clk);
      s_ena = 1'b0;
    end
    repeat (4) @(negedge clk);

    check("main_queue_left", q_main.size(), 0, 0);
    check("sat_queue_left", q_small.size(), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
